// File: rtl/tlul_timeout_tracker.sv
// TL-UL host-to-device shim that tracks outstanding A-channel requests in order and
// recovers from a hung device by answering the oldest request with an error response.
// The device's late response to a timed-out request is later absorbed and dropped.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                timer enable
//   timeout_limit_i         cycles before timeout (0 disables)
//   h_a_*  / h_a_ready_o    host A channel in, passed through to d_a_* / d_a_ready_i
//   d_d_*  / d_d_ready_o    device D channel in, forwarded (or replaced) on h_d_* / h_d_ready_i
//   outstanding_o           live tracked entries
//   timeout_o               one-cycle pulse per timeout
//   protocol_err_o          sticky protocol-error flag
module tlul_timeout_tracker #(
  parameter int unsigned      DataW    = 32,
  parameter int unsigned      AddrW    = 32,
  parameter int unsigned      SrcW     = 8,
  parameter int unsigned      Depth    = 4,
  parameter int unsigned      TimeoutW = 16,
  parameter logic [DataW-1:0] ErrData  = {DataW{1'b1}}
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [TimeoutW-1:0]          timeout_limit_i,
  // host A
  input  logic                         h_a_valid_i,
  input  logic [2:0]                   h_a_opcode_i,
  input  logic [1:0]                   h_a_size_i,
  input  logic [SrcW-1:0]              h_a_source_i,
  input  logic [AddrW-1:0]             h_a_address_i,
  input  logic [DataW-1:0]             h_a_data_i,
  input  logic [DataW/8-1:0]           h_a_mask_i,
  output logic                         h_a_ready_o,
  // device A
  output logic                         d_a_valid_o,
  output logic [2:0]                   d_a_opcode_o,
  output logic [1:0]                   d_a_size_o,
  output logic [SrcW-1:0]              d_a_source_o,
  output logic [AddrW-1:0]             d_a_address_o,
  output logic [DataW-1:0]             d_a_data_o,
  output logic [DataW/8-1:0]           d_a_mask_o,
  input  logic                         d_a_ready_i,
  // device D
  input  logic                         d_d_valid_i,
  input  logic [2:0]                   d_d_opcode_i,
  input  logic [1:0]                   d_d_size_i,
  input  logic [SrcW-1:0]              d_d_source_i,
  input  logic [DataW-1:0]             d_d_data_i,
  input  logic                         d_d_error_i,
  output logic                         d_d_ready_o,
  // host D
  output logic                         h_d_valid_o,
  output logic [2:0]                   h_d_opcode_o,
  output logic [1:0]                   h_d_size_o,
  output logic [SrcW-1:0]              h_d_source_o,
  output logic [DataW-1:0]             h_d_data_o,
  output logic                         h_d_error_o,
  input  logic                         h_d_ready_i,
  // status
  output logic [$clog2(Depth+1)-1:0]   outstanding_o,
  output logic                         timeout_o,
  output logic                         protocol_err_o
);

  localparam int unsigned CntW   = $clog2(Depth + 1);
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned EntryW = SrcW + 2 + 3;

  typedef enum logic [1:0] {StIdle, StWait, StErrRsp} state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   fifo_q [Depth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     stale_q, stale_d;
  logic [TimeoutW-1:0] timer_q, timer_d;
  logic                perr_q, perr_d;

  logic                blocked, a_hs, pop, fire;
  logic                stale_inc, stale_dec, perr_set, fifo_empty;
  logic [CntW:0]       occupancy;
  logic [2:0]          rsp_op;
  logic [EntryW-1:0]   head;
  logic [2:0]          head_op;
  logic [1:0]          head_size;
  logic [SrcW-1:0]     head_src;

  // Stale entries still occupy device-side slots, so they count against Depth.
  assign occupancy  = {1'b0, cnt_q} + {1'b0, stale_q};
  assign blocked    = (occupancy == (CntW + 1)'(Depth));
  assign fifo_empty = (cnt_q == '0);

  // A channel: pure pass-through, throttled when tracking is full.
  assign d_a_valid_o   = h_a_valid_i & ~blocked & ~rst_i;
  assign h_a_ready_o   = d_a_ready_i & ~blocked & ~rst_i;
  assign d_a_opcode_o  = h_a_opcode_i;
  assign d_a_size_o    = h_a_size_i;
  assign d_a_source_o  = h_a_source_i;
  assign d_a_address_o = h_a_address_i;
  assign d_a_data_o    = h_a_data_i;
  assign d_a_mask_o    = h_a_mask_i;
  assign a_hs          = h_a_valid_i & d_a_ready_i & ~blocked & ~rst_i;

  // Get expects AccessAckData; puts expect AccessAck.
  assign rsp_op = (h_a_opcode_i == 3'd4) ? 3'd1 : 3'd0;

  assign head      = fifo_q[rptr_q];
  assign head_op   = head[2:0];
  assign head_size = head[4:3];
  assign head_src  = head[EntryW-1:5];

  // D path and timeout detection
  always_comb begin
    h_d_valid_o  = 1'b0;
    h_d_opcode_o = d_d_opcode_i;
    h_d_size_o   = d_d_size_i;
    h_d_source_o = d_d_source_i;
    h_d_data_o   = d_d_data_i;
    h_d_error_o  = d_d_error_i;
    d_d_ready_o  = 1'b0;
    pop          = 1'b0;
    stale_inc    = 1'b0;
    stale_dec    = 1'b0;
    perr_set     = 1'b0;
    fire         = 1'b0;
    unique case (state_q)
      StIdle, StWait: begin
        if (stale_q != '0) begin
          // Late answer to a request already errored back to the host.
          d_d_ready_o = 1'b1;
          stale_dec   = d_d_valid_i;
        end else if (fifo_empty) begin
          // Unsolicited response: swallow it and flag.
          d_d_ready_o = 1'b1;
          perr_set    = d_d_valid_i;
        end else begin
          h_d_valid_o = d_d_valid_i;
          d_d_ready_o = h_d_ready_i;
          pop         = d_d_valid_i & h_d_ready_i;
          perr_set    = d_d_valid_i & (d_d_source_i != head_src);
        end
        // A response arriving in the same cycle beats the timeout.
        fire = (state_q == StWait) & ~fifo_empty & (timeout_limit_i != '0) &
               (timer_q == timeout_limit_i) & ~d_d_valid_i;
      end
      StErrRsp: begin
        h_d_valid_o  = 1'b1;
        h_d_opcode_o = head_op;
        h_d_size_o   = head_size;
        h_d_source_o = head_src;
        h_d_data_o   = ErrData;
        h_d_error_o  = 1'b1;
        pop          = h_d_ready_i;
        stale_inc    = h_d_ready_i;
      end
      default: ;
    endcase
    if (rst_i) begin
      h_d_valid_o = 1'b0;
      d_d_ready_o = 1'b0;
      fire        = 1'b0;
    end
  end

  assign timeout_o      = fire;
  assign outstanding_o  = cnt_q;
  assign protocol_err_o = perr_q;

  // Next-state
  always_comb begin
    cnt_d   = cnt_q + CntW'(a_hs) - CntW'(pop);
    stale_d = stale_q + CntW'(stale_inc) - CntW'(stale_dec);
    perr_d  = perr_q | perr_set;

    if (fire) begin
      state_d = StErrRsp;
    end else if ((state_q == StErrRsp) && !pop) begin
      state_d = StErrRsp;
    end else begin
      state_d = (cnt_d == '0) ? StIdle : StWait;
    end

    timer_d = timer_q;
    if (!enable_i || pop || (state_d == StIdle)) begin
      timer_d = '0;
    end else if ((state_q == StWait) && (timer_q != '1)) begin
      timer_d = timer_q + TimeoutW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      stale_q <= '0;
      timer_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      timer_q <= timer_d;
      perr_q  <= perr_d;
      if (a_hs) begin
        wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      end
    end
  end

  // Tracking storage needs no reset; occupancy is governed by cnt_q.
  always_ff @(posedge clk_i) begin
    if (a_hs) begin
      fifo_q[wptr_q] <= {h_a_source_i, h_a_size_i, rsp_op};
    end
  end

endmodule

// File: tb/tb_tlul_timeout_tracker.sv
module tb_tlul_timeout_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [15:0] timeout_limit_i;
  logic        h_a_valid_i;
  logic [2:0]  h_a_opcode_i;
  logic [1:0]  h_a_size_i;
  logic [7:0]  h_a_source_i;
  logic [31:0] h_a_address_i;
  logic [31:0] h_a_data_i;
  logic [3:0]  h_a_mask_i;
  logic        h_a_ready_o;
  logic        d_a_valid_o;
  logic [2:0]  d_a_opcode_o;
  logic [1:0]  d_a_size_o;
  logic [7:0]  d_a_source_o;
  logic [31:0] d_a_address_o;
  logic [31:0] d_a_data_o;
  logic [3:0]  d_a_mask_o;
  logic        d_a_ready_i;
  logic        d_d_valid_i;
  logic [2:0]  d_d_opcode_i;
  logic [1:0]  d_d_size_i;
  logic [7:0]  d_d_source_i;
  logic [31:0] d_d_data_i;
  logic        d_d_error_i;
  logic        d_d_ready_o;
  logic        h_d_valid_o;
  logic [2:0]  h_d_opcode_o;
  logic [1:0]  h_d_size_o;
  logic [7:0]  h_d_source_o;
  logic [31:0] h_d_data_o;
  logic        h_d_error_o;
  logic        h_d_ready_i;
  logic [2:0]  outstanding_o;
  logic        timeout_o;
  logic        protocol_err_o;

  int checks = 0;
  int failures = 0;

  tlul_timeout_tracker dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .timeout_limit_i (timeout_limit_i),
    .h_a_valid_i     (h_a_valid_i),
    .h_a_opcode_i    (h_a_opcode_i),
    .h_a_size_i      (h_a_size_i),
    .h_a_source_i    (h_a_source_i),
    .h_a_address_i   (h_a_address_i),
    .h_a_data_i      (h_a_data_i),
    .h_a_mask_i      (h_a_mask_i),
    .h_a_ready_o     (h_a_ready_o),
    .d_a_valid_o     (d_a_valid_o),
    .d_a_opcode_o    (d_a_opcode_o),
    .d_a_size_o      (d_a_size_o),
    .d_a_source_o    (d_a_source_o),
    .d_a_address_o   (d_a_address_o),
    .d_a_data_o      (d_a_data_o),
    .d_a_mask_o      (d_a_mask_o),
    .d_a_ready_i     (d_a_ready_i),
    .d_d_valid_i     (d_d_valid_i),
    .d_d_opcode_i    (d_d_opcode_i),
    .d_d_size_i      (d_d_size_i),
    .d_d_source_i    (d_d_source_i),
    .d_d_data_i      (d_d_data_i),
    .d_d_error_i     (d_d_error_i),
    .d_d_ready_o     (d_d_ready_o),
    .h_d_valid_o     (h_d_valid_o),
    .h_d_opcode_o    (h_d_opcode_o),
    .h_d_size_o      (h_d_size_o),
    .h_d_source_o    (h_d_source_o),
    .h_d_data_o      (h_d_data_o),
    .h_d_error_o     (h_d_error_o),
    .h_d_ready_i     (h_d_ready_i),
    .outstanding_o   (outstanding_o),
    .timeout_o       (timeout_o),
    .protocol_err_o  (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    h_a_valid_i   = 1'b0;
    h_a_opcode_i  = 3'd0;
    h_a_size_i    = 2'd2;
    h_a_source_i  = 8'd0;
    h_a_address_i = 32'h0;
    h_a_data_i    = 32'h0;
    h_a_mask_i    = 4'hF;
    d_d_valid_i   = 1'b0;
    d_d_opcode_i  = 3'd0;
    d_d_size_i    = 2'd2;
    d_d_source_i  = 8'd0;
    d_d_data_i    = 32'h0;
    d_d_error_i   = 1'b0;
    h_d_ready_i   = 1'b0;
    d_a_ready_i   = 1'b1;
  endtask

  // Present a Get for one cycle, accepted by the device.
  task automatic push_get(input logic [7:0] src);
    h_a_valid_i  = 1'b1;
    h_a_opcode_i = 3'd4;
    h_a_source_i = src;
    d_a_ready_i  = 1'b1;
    step();
    h_a_valid_i  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    h_a_valid_i = 1'b1;
    d_d_valid_i = 1'b1;
    h_d_ready_i = 1'b1;
    step();
    step();
    checks++;
    if ({h_a_ready_o, d_a_valid_o, d_d_ready_o, h_d_valid_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_rdy_vld got=%b exp=0000",
               {h_a_ready_o, d_a_valid_o, d_d_ready_o, h_d_valid_o});
    end
    checks++;
    if ({outstanding_o, timeout_o, protocol_err_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state got out=%0d to=%b perr=%b exp 0/0/0",
               outstanding_o, timeout_o, protocol_err_o);
    end
    idle_inputs();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_get_response();
    bit saw_to = 1'b0;
    timeout_limit_i = 16'd100;
    h_a_valid_i  = 1'b1;
    h_a_opcode_i = 3'd4;
    h_a_source_i = 8'd3;
    #1;
    checks++;
    if ({h_a_ready_o, d_a_valid_o, d_a_source_o, d_a_opcode_o} !== {2'b11, 8'd3, 3'd4}) begin
      failures++;
      $display("FAIL get_a_pass got rdy=%b vld=%b src=%0d op=%0d exp 1 1 3 4",
               h_a_ready_o, d_a_valid_o, d_a_source_o, d_a_opcode_o);
    end
    step();
    h_a_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL get_out1 got=%0d exp=1", outstanding_o);
    end
    for (int i = 0; i < 5; i++) begin
      if (timeout_o) saw_to = 1'b1;
      step();
    end
    d_d_valid_i  = 1'b1;
    d_d_opcode_i = 3'd1;
    d_d_source_i = 8'd3;
    d_d_data_i   = 32'h0000_1234;
    h_d_ready_i  = 1'b1;
    #1;
    checks++;
    if ({h_d_valid_o, h_d_opcode_o, h_d_source_o, h_d_data_o, h_d_error_o, d_d_ready_o} !==
        {1'b1, 3'd1, 8'd3, 32'h0000_1234, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL get_d_fwd got v=%b op=%0d src=%0d data=%h err=%b rdy=%b exp 1 1 3 1234 0 1",
               h_d_valid_o, h_d_opcode_o, h_d_source_o, h_d_data_o, h_d_error_o, d_d_ready_o);
    end
    if (timeout_o) saw_to = 1'b1;
    step();
    idle_inputs();
    #1;
    checks++;
    if (outstanding_o !== 3'd0) begin
      failures++;
      $display("FAIL get_out0 got=%0d exp=0", outstanding_o);
    end
    checks++;
    if ({saw_to, protocol_err_o} !== 2'b00) begin
      failures++;
      $display("FAIL get_no_timeout got to=%b perr=%b exp 0 0", saw_to, protocol_err_o);
    end
  endtask

  task automatic test_back_to_back();
    timeout_limit_i = 16'd0;
    h_a_opcode_i    = 3'd0;
    for (int i = 0; i < 5; i++) begin
      h_a_valid_i  = 1'b1;
      h_a_source_i = 8'(i);
      #1;
      checks++;
      if ({h_a_ready_o, d_a_valid_o} !== {2{i < 4}}) begin
        failures++;
        $display("FAIL b2b_ready%0d got=%b%b exp=%b", i, h_a_ready_o, d_a_valid_o, {2{i < 4}});
      end
      step();
    end
    h_a_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 3'd4) begin
      failures++;
      $display("FAIL b2b_out4 got=%0d exp=4", outstanding_o);
    end
    // Drain in order; an out-of-order head would raise protocol_err_o.
    for (int i = 0; i < 4; i++) begin
      d_d_valid_i  = 1'b1;
      d_d_source_i = 8'(i);
      h_d_ready_i  = 1'b1;
      #1;
      checks++;
      if ({h_d_valid_o, h_d_source_o} !== {1'b1, 8'(i)}) begin
        failures++;
        $display("FAIL b2b_drain%0d got v=%b src=%0d exp 1 %0d", i, h_d_valid_o, h_d_source_o, i);
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if ({outstanding_o, protocol_err_o} !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_drained got out=%0d perr=%b exp 0 0", outstanding_o, protocol_err_o);
    end
  endtask

  task automatic test_timeout();
    int fired_at = -1;
    timeout_limit_i = 16'd10;
    push_get(8'd7);
    for (int k = 0; k < 20; k++) begin
      if (timeout_o) begin
        fired_at = k;
        break;
      end
      step();
    end
    checks++;
    if (fired_at != 10) begin
      failures++;
      $display("FAIL to_cycle got=%0d exp=10", fired_at);
    end
    h_d_ready_i = 1'b0;
    step();
    for (int r = 0; r < 2; r++) begin
      checks++;
      if ({h_d_valid_o, h_d_source_o, h_d_opcode_o, h_d_data_o, h_d_error_o, d_d_ready_o,
           timeout_o} !== {1'b1, 8'd7, 3'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL to_err_rsp%0d got v=%b src=%0d op=%0d data=%h err=%b drdy=%b to=%b exp 1 7 1 ffffffff 1 0 0",
                 r, h_d_valid_o, h_d_source_o, h_d_opcode_o, h_d_data_o, h_d_error_o,
                 d_d_ready_o, timeout_o);
      end
      step();
    end
    h_d_ready_i = 1'b1;
    step();
    checks++;
    if ({h_d_valid_o, outstanding_o} !== 4'b0000) begin
      failures++;
      $display("FAIL to_popped got v=%b out=%0d exp 0 0", h_d_valid_o, outstanding_o);
    end
    step();
    d_d_valid_i  = 1'b1;
    d_d_source_i = 8'd7;
    d_d_opcode_i = 3'd1;
    #1;
    checks++;
    if ({h_d_valid_o, d_d_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL to_stale_drop got hv=%b drdy=%b exp 0 1", h_d_valid_o, d_d_ready_o);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (protocol_err_o !== 1'b0) begin
      failures++;
      $display("FAIL to_stale_perr got=%b exp=0", protocol_err_o);
    end
  endtask

  task automatic test_same_cycle();
    bit saw_to = 1'b0;
    timeout_limit_i = 16'd10;
    push_get(8'd4);
    for (int k = 0; k < 10; k++) begin
      if (timeout_o) saw_to = 1'b1;
      step();
    end
    // Timer now equals the limit; the response lands in this very cycle.
    d_d_valid_i  = 1'b1;
    d_d_source_i = 8'd4;
    d_d_opcode_i = 3'd1;
    d_d_data_i   = 32'h0000_ABCD;
    h_d_ready_i  = 1'b1;
    #1;
    if (timeout_o) saw_to = 1'b1;
    checks++;
    if ({h_d_valid_o, h_d_data_o, h_d_error_o} !== {1'b1, 32'h0000_ABCD, 1'b0}) begin
      failures++;
      $display("FAIL race_fwd got v=%b data=%h err=%b exp 1 abcd 0",
               h_d_valid_o, h_d_data_o, h_d_error_o);
    end
    step();
    idle_inputs();
    #1;
    if (timeout_o) saw_to = 1'b1;
    checks++;
    if ({saw_to, outstanding_o, h_d_valid_o} !== 5'b0) begin
      failures++;
      $display("FAIL race_no_to got to=%b out=%0d hv=%b exp 0 0 0", saw_to, outstanding_o,
               h_d_valid_o);
    end
  endtask

  task automatic test_protocol_err();
    timeout_limit_i = 16'd0;
    push_get(8'd2);
    d_d_valid_i  = 1'b1;
    d_d_source_i = 8'd5;
    h_d_ready_i  = 1'b1;
    #1;
    checks++;
    if ({h_d_valid_o, h_d_source_o} !== {1'b1, 8'd5}) begin
      failures++;
      $display("FAIL perr_fwd got v=%b src=%0d exp 1 5", h_d_valid_o, h_d_source_o);
    end
    step();
    idle_inputs();
    step();
    step();
    checks++;
    if ({protocol_err_o, outstanding_o} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL perr_sticky got perr=%b out=%0d exp 1 0", protocol_err_o, outstanding_o);
    end
  endtask

  task automatic test_reset_mid();
    timeout_limit_i = 16'd0;
    push_get(8'd1);
    push_get(8'd2);
    push_get(8'd3);
    checks++;
    if (outstanding_o !== 3'd3) begin
      failures++;
      $display("FAIL rmid_out3 got=%0d exp=3", outstanding_o);
    end
    rst_i       = 1'b1;
    h_a_valid_i = 1'b1;
    d_d_valid_i = 1'b1;
    h_d_ready_i = 1'b1;
    step();
    rst_i = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({outstanding_o, h_d_valid_o, protocol_err_o, h_a_ready_o} !== {3'd0, 3'b001}) begin
      failures++;
      $display("FAIL rmid_cleared got out=%0d hv=%b perr=%b ardy=%b exp 0 0 0 1",
               outstanding_o, h_d_valid_o, protocol_err_o, h_a_ready_o);
    end
    d_a_ready_i = 1'b0;
    #1;
    checks++;
    if (h_a_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rmid_ardy_follow got=%b exp=0", h_a_ready_o);
    end
    d_a_ready_i = 1'b1;
  endtask

  initial begin
    enable_i        = 1'b1;
    timeout_limit_i = 16'd0;
    idle_inputs();
    test_reset();
    test_get_response();
    test_back_to_back();
    test_timeout();
    test_same_cycle();
    test_protocol_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlul_timeout_tracker.md
Name: tlul_timeout_tracker

Overview:
Single-clock TL-UL host-to-device shim, parametrised in data/address/source width and outstanding depth. It tracks outstanding A-channel requests in order and times out the oldest one. On timeout it returns a TL-UL error response to the host and later silently discards the device's stale response. It sits on the xbar_peri side of the CDC adapter, in front of slow or hang-prone peripherals, and generalises the adapter's single-shot timeout into per-transaction recovery.

Parameters:
DataW, 32, data width (multiple of 8)
AddrW, 32, address width
SrcW, 8, a_source/d_source width
Depth, 4, max outstanding transactions (>=1)
TimeoutW, 16, timer/limit width
ErrData, {DataW{1'b1}}, d_data returned on timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  timer enable
timeout_limit_i  in  TimeoutW  cycles before timeout; 0 = disabled
h_a_valid_i, h_a_opcode_i[3], h_a_size_i[2], h_a_source_i[SrcW], h_a_address_i[AddrW], h_a_data_i[DataW], h_a_mask_i[DataW/8]  in  host A channel
h_a_ready_o  out  1  host A ready
d_a_valid_o, d_a_opcode_o, d_a_size_o, d_a_source_o, d_a_address_o, d_a_data_o, d_a_mask_o  out  device A channel (same widths)
d_a_ready_i  in  1  device A ready
d_d_valid_i, d_d_opcode_i[3], d_d_size_i[2], d_d_source_i[SrcW], d_d_data_i[DataW], d_d_error_i[1]  in  device D channel
d_d_ready_o  out  1  device D ready
h_d_valid_o, h_d_opcode_o, h_d_size_o, h_d_source_o, h_d_data_o, h_d_error_o  out  host D channel (same widths)
h_d_ready_i  in  1  host D ready
outstanding_o  out  $clog2(Depth+1)  live entries
timeout_o  out  1  one-cycle pulse per timeout
protocol_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (clk_i edge with rst_i=1): tracking FIFO empty, stale_cnt=0, timer=0, FSM=IDLE, protocol_err_o=0, timeout_o=0; all valid/ready outputs 0. A reset mid-transaction abandons all tracking.
- A path: combinational pass-through. blocked = (outstanding+stale_cnt==Depth). d_a_valid_o = h_a_valid_i & !blocked; h_a_ready_o = d_a_ready_i & !blocked.
- On A handshake, push {source, size, rsp_opcode}: Get(4) -> AccessAckData(1); PutFull(0)/PutPartial(1) -> AccessAck(0).
- FSM states:
  - IDLE: outstanding==0.
  - WAIT: outstanding>0.
  - ERR_RSP: generating an error response.
- D path in IDLE/WAIT:
  - If stale_cnt>0: d_d_ready_o=1, response discarded, stale_cnt--, host sees nothing.
  - Otherwise pass through with d_d_ready_o=h_d_ready_i. Handshake pops the head.
  - d_d_source_i != head source: response still forwarded, protocol_err_o set.
  - d_d_valid_i with FIFO empty and stale_cnt==0: response consumed and dropped, protocol_err_o set.
- Timer:
  - Increments each cycle in WAIT while enable_i=1.
  - Cleared on head pop, on entering IDLE, and while enable_i=0.
  - Saturates; never wraps.
- Timeout fires when timeout_limit_i!=0, timer==timeout_limit_i and d_d_valid_i=0 that cycle. A device response in the same cycle wins and no timeout occurs.
- On fire: timeout_o pulses and FSM -> ERR_RSP.
- ERR_RSP:
  - Drives h_d_valid_o=1 with head source/size/opcode, h_d_data_o=ErrData, h_d_error_o=1.
  - d_d_ready_o=0.
  - Outputs held stable until h_d_ready_i.
  - On handshake: pop head, stale_cnt++, timer=0, FSM -> WAIT or IDLE.
- Simultaneous A push and D pop: outstanding unchanged.
- stale_cnt width $clog2(Depth+1); outstanding+stale_cnt never exceeds Depth.

Test Plan:
- Get src=3, device responds after 5 cycles with data 0x1234, limit=100 -> host gets AccessAckData src=3 data=0x1234 error=0; outstanding_o 1->0; no timeout_o.
- Depth=4, device d_a_ready_i=1 and no D responses, 5 back-to-back Puts -> 4 accepted, h_a_ready_o=0 on 5th; outstanding_o=4.
- limit=10, one Get src=7, no device response -> timeout_o pulses 10 cycles after push; host gets src=7 error=1 data=0xFFFFFFFF; late device response later consumed and not forwarded.
- Device D valid in exactly the cycle timer==limit -> response forwarded normally, timeout_o stays 0.
- Device response with source 5 while head is 2 -> forwarded, protocol_err_o=1 and stays 1 until rst_i.
- rst_i asserted with 3 outstanding -> next cycle outstanding_o=0, h_d_valid_o=0, h_a_ready_o follows d_a_ready_i.
